// File: rtl/alu.sv
// alu: 16-bit ALU with a registered result and registered zero/negative flags
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inA,
    input  logic [15:0] inB,
    input  logic        inc,
    input  logic [2:0]  opc,
    output logic [15:0] w,
    output logic        zer,
    output logic        neg
);
    logic [15:0] w_d, w_q;
    logic        zer_d, zer_q, neg_d, neg_q;
    always_comb begin
        w_d = opc == 3'd0 ? inA + inB + {15'd0, inc} :
              opc == 3'd1 ? inA + ~inB + {15'd0, ~inc} :
              opc == 3'd2 ? inA & inB :
              opc == 3'd3 ? inA | inB :
              opc == 3'd4 ? inA ^ inB :
              opc == 3'd5 ? ~inA :
              opc == 3'd6 ? {inA[15], inA[15:1]} :
                            inB;
        zer_d = w_d == 16'h0000;
        neg_d = w_d[15];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q   <= 16'h0000;
            zer_q <= 1'b1;
            neg_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            zer_q <= zer_d;
            neg_q <= neg_d;
        end
    end
    assign w   = w_q;
    assign zer = zer_q;
    assign neg = neg_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized self-checking bench for alu
module tb_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inA = 16'h0, inB = 16'h0;
    logic        inc = 1'b0;
    logic [2:0]  opc = 3'd0;
    logic [15:0] w;
    logic        zer, neg;
    int          checks = 0, errors = 0;
    alu dut (.clk(clk), .rst(rst), .inA(inA), .inB(inB), .inc(inc), .opc(opc),
             .w(w), .zer(zer), .neg(neg));
    always #5 clk = ~clk;
    function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [15:0] v;
        case (o)
            3'd0: v = a + b + 16'(c);
            3'd1: v = a - b - 16'(c);
            3'd2: v = a & b;
            3'd3: v = a | b;
            3'd4: v = a ^ b;
            3'd5: v = ~a;
            3'd6: v = 16'($signed(a) >>> 1);
            default: v = b;
        endcase
        return v;
    endfunction
    function automatic logic [17:0] pk(input logic [15:0] v);
        return {v, v == 16'h0000, v[15]};
    endfunction
    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: w/zer/neg got %h_%b%b expected %h_%b%b", tag,
                     got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
        end
    endtask
    task automatic apply(input logic r, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        rst = r; opc = o; inA = a; inB = b; inc = c;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [15:0] ra, rb;
        logic        rc, rr;
        logic [2:0]  ro;
        apply(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
        apply(1'b1, 3'd5, 16'h0000, 16'h1234, 1'b1);
        chk("reset", {w, zer, neg}, {16'h0000, 1'b1, 1'b0});
        apply(1'b0, 3'd0, 16'h0001, 16'h0002, 1'b0); chk("add_basic", {w, zer, neg}, pk(16'h0003));
        apply(1'b0, 3'd0, 16'h7FFF, 16'h0000, 1'b1); chk("add_carry", {w, zer, neg}, {16'h8000, 1'b0, 1'b1});
        apply(1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b1); chk("add_wrap", {w, zer, neg}, {16'h0000, 1'b1, 1'b0});
        apply(1'b0, 3'd1, 16'h0005, 16'h0005, 1'b0); chk("sub_zero", {w, zer, neg}, {16'h0000, 1'b1, 1'b0});
        apply(1'b0, 3'd1, 16'h0005, 16'h0005, 1'b1); chk("sub_borrow", {w, zer, neg}, {16'hFFFF, 1'b0, 1'b1});
        apply(1'b0, 3'd1, 16'h1234, 16'h0234, 1'b0); chk("sub_basic", {w, zer, neg}, {16'h1000, 1'b0, 1'b0});
        apply(1'b0, 3'd2, 16'hF0F0, 16'h0FF0, 1'b1); chk("and", {w, zer, neg}, {16'h00F0, 1'b0, 1'b0});
        apply(1'b0, 3'd3, 16'hF0F0, 16'h0FF0, 1'b1); chk("or", {w, zer, neg}, {16'hFFF0, 1'b0, 1'b1});
        apply(1'b0, 3'd4, 16'hF0F0, 16'h0FF0, 1'b1); chk("xor", {w, zer, neg}, {16'hFF00, 1'b0, 1'b1});
        apply(1'b0, 3'd5, 16'hF0F0, 16'h0FF0, 1'b1); chk("not", {w, zer, neg}, {16'h0F0F, 1'b0, 1'b0});
        apply(1'b0, 3'd6, 16'hF0F0, 16'h0FF0, 1'b1); chk("sra", {w, zer, neg}, {16'hF878, 1'b0, 1'b1});
        apply(1'b0, 3'd7, 16'hF0F0, 16'h0FF0, 1'b1); chk("pass", {w, zer, neg}, {16'h0FF0, 1'b0, 1'b0});
        apply(1'b0, 3'd6, 16'h7FFE, 16'h0000, 1'b0); chk("sra_pos", {w, zer, neg}, {16'h3FFF, 1'b0, 1'b0});
        apply(1'b1, 3'd7, 16'h0000, 16'h8000, 1'b0); chk("reset_mid", {w, zer, neg}, {16'h0000, 1'b1, 1'b0});
        apply(1'b0, 3'd7, 16'h0000, 16'h8000, 1'b0); chk("after_reset", {w, zer, neg}, {16'h8000, 1'b0, 1'b1});
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 3'(i), ra, rb, rc);
            chk($sformatf("sweep_op%0d", i), {w, zer, neg}, pk(model(3'(i), ra, rb, rc)));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ro = 3'($urandom); rr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 7) == 0) rb = ra;
            apply(rr, ro, ra, rb, rc);
            chk($sformatf("rand%0d_op%0d_rst%0d", i, ro, rr), {w, zer, neg},
                rr ? {16'h0000, 1'b1, 1'b0} : pk(model(ro, ra, rb, rc)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
